// File: rtl/rob_pkg.sv
// Shared types and default widths for the reorder buffer.
package rob_pkg;

  localparam int unsigned DefaultDepth = 16;
  localparam int unsigned AregW        = 5;
  localparam int unsigned PregW        = 6;
  localparam int unsigned PcW          = 32;

  typedef struct packed {
    logic             valid;
    logic             done;
    logic             exc;
    logic             has_rd;
    logic [AregW-1:0] arch_rd;
    logic [PregW-1:0] preg;
    logic [PregW-1:0] old_preg;
    logic [PcW-1:0]   pc;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// Dispatch, writeback and retirement signals of the reorder buffer.
interface reorder_buffer_if #(
  parameter int unsigned DEPTH  = rob_pkg::DefaultDepth,
  parameter int unsigned AREG_W = rob_pkg::AregW,
  parameter int unsigned PREG_W = rob_pkg::PregW,
  parameter int unsigned PC_W   = rob_pkg::PcW
);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic              alloc_valid;
  logic              alloc_has_rd;
  logic [AREG_W-1:0] alloc_arch_rd;
  logic [PREG_W-1:0] alloc_preg;
  logic [PREG_W-1:0] alloc_old_preg;
  logic [PC_W-1:0]   alloc_pc;
  logic [IDX_W-1:0]  alloc_tag;
  logic              rob_full;
  logic              rob_empty;
  logic [IDX_W:0]    rob_count;

  logic              complete_valid;
  logic [IDX_W-1:0]  complete_tag;
  logic              complete_exc;

  logic              commit_valid;
  logic              commit_has_rd;
  logic [AREG_W-1:0] commit_arch_rd;
  logic [PREG_W-1:0] commit_preg;
  logic [PREG_W-1:0] commit_old_preg;
  logic              flush;
  logic [PC_W-1:0]   flush_pc;

  modport master (
    output alloc_valid, alloc_has_rd, alloc_arch_rd, alloc_preg, alloc_old_preg, alloc_pc,
    output complete_valid, complete_tag, complete_exc,
    input  alloc_tag, rob_full, rob_empty, rob_count,
    input  commit_valid, commit_has_rd, commit_arch_rd, commit_preg, commit_old_preg,
    input  flush, flush_pc
  );

  modport slave (
    input  alloc_valid, alloc_has_rd, alloc_arch_rd, alloc_preg, alloc_old_preg, alloc_pc,
    input  complete_valid, complete_tag, complete_exc,
    output alloc_tag, rob_full, rob_empty, rob_count,
    output commit_valid, commit_has_rd, commit_arch_rd, commit_preg, commit_old_preg,
    output flush, flush_pc
  );

endinterface

// File: rtl/rob_ptr.sv
// Wrap-around ring pointer; DEPTH is a power of two so the natural overflow wraps.
module rob_ptr #(
  parameter int unsigned IDX_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  input  logic             clear_i,
  output logic [IDX_W-1:0] ptr_o
);

  logic [IDX_W-1:0] ptr_d, ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (clear_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = ptr_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates at tail, completes out of order, retires from head.
module reorder_buffer
  import rob_pkg::*;
#(
  parameter int unsigned DEPTH  = DefaultDepth,
  parameter int unsigned AREG_W = AregW,
  parameter int unsigned PREG_W = PregW,
  parameter int unsigned PC_W   = PcW
) (
  input logic             clk,
  input logic             reset,
  reorder_buffer_if.slave rob
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  rob_entry_t       entries_q [DEPTH];
  rob_entry_t       entries_d [DEPTH];
  rob_entry_t       head_e;
  logic [IDX_W-1:0] head_q, tail_q;
  logic [IDX_W:0]   count_q, count_d;
  logic             full, alloc_acc, commit, flush;

  rob_ptr #(
    .IDX_W(IDX_W)
  ) u_head_ptr (
    .clk    (clk),
    .reset  (reset),
    .inc_i  (commit),
    .clear_i(flush),
    .ptr_o  (head_q)
  );

  rob_ptr #(
    .IDX_W(IDX_W)
  ) u_tail_ptr (
    .clk    (clk),
    .reset  (reset),
    .inc_i  (alloc_acc),
    .clear_i(flush),
    .ptr_o  (tail_q)
  );

  assign head_e    = entries_q[head_q];
  assign full      = (count_q == (IDX_W+1)'(DEPTH));
  assign commit    = head_e.valid & head_e.done & ~head_e.exc;
  assign flush     = head_e.valid & head_e.done & head_e.exc;
  // Full is judged on registered count, so a same-cycle commit never frees room for an alloc.
  assign alloc_acc = rob.alloc_valid & ~full & ~flush;

  always_comb begin
    entries_d = entries_q;
    if (alloc_acc) begin
      entries_d[tail_q] = '{
        valid:    1'b1,
        done:     1'b0,
        exc:      1'b0,
        has_rd:   rob.alloc_has_rd,
        arch_rd:  AregW'(rob.alloc_arch_rd),
        preg:     PregW'(rob.alloc_preg),
        old_preg: PregW'(rob.alloc_old_preg),
        pc:       PcW'(rob.alloc_pc)
      };
    end
    if (rob.complete_valid && entries_q[rob.complete_tag].valid) begin
      entries_d[rob.complete_tag].done = 1'b1;
      entries_d[rob.complete_tag].exc  = rob.complete_exc;
    end
    if (commit) begin
      entries_d[head_q].valid = 1'b0;
    end
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_d[i].valid = 1'b0;
        entries_d[i].done  = 1'b0;
        entries_d[i].exc   = 1'b0;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (alloc_acc && !commit) begin
      count_d = count_q + (IDX_W+1)'(1);
    end else if (!alloc_acc && commit) begin
      count_d = count_q - (IDX_W+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      entries_q <= entries_d;
      count_q   <= count_d;
    end
  end

  assign rob.alloc_tag       = tail_q;
  assign rob.rob_full        = full;
  assign rob.rob_empty       = (count_q == '0);
  assign rob.rob_count       = count_q;
  assign rob.commit_valid    = commit;
  assign rob.commit_has_rd   = head_e.has_rd;
  assign rob.commit_arch_rd  = AREG_W'(head_e.arch_rd);
  assign rob.commit_preg     = PREG_W'(head_e.preg);
  assign rob.commit_old_preg = PREG_W'(head_e.old_preg);
  assign rob.flush           = flush;
  assign rob.flush_pc        = PC_W'(head_e.pc);

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed checks of allocation, out-of-order completion, wrap, full handling and flush.
module tb_reorder_buffer;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  reorder_buffer_if rob_if ();

  reorder_buffer u_dut (
    .clk  (clk),
    .reset(reset),
    .rob  (rob_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    rob_if.alloc_valid    = 1'b0;
    rob_if.alloc_has_rd   = 1'b0;
    rob_if.alloc_arch_rd  = '0;
    rob_if.alloc_preg     = '0;
    rob_if.alloc_old_preg = '0;
    rob_if.alloc_pc       = '0;
    rob_if.complete_valid = 1'b0;
    rob_if.complete_tag   = '0;
    rob_if.complete_exc   = 1'b0;
  endtask

  // Instruction n: has_rd = !n[0], arch_rd = n[4:0], preg = n[5:0], old_preg = ~n[5:0],
  // pc = 0x1000 + 4n.
  task automatic drive_alloc(input int n);
    logic [31:0] nn;
    nn = n;
    rob_if.alloc_valid    = 1'b1;
    rob_if.alloc_has_rd   = ~nn[0];
    rob_if.alloc_arch_rd  = nn[4:0];
    rob_if.alloc_preg     = nn[5:0];
    rob_if.alloc_old_preg = ~nn[5:0];
    rob_if.alloc_pc       = 32'h1000 + (nn << 2);
  endtask

  task automatic drive_complete(input int tag, input logic exc);
    rob_if.complete_valid = 1'b1;
    rob_if.complete_tag   = 4'(tag);
    rob_if.complete_exc   = exc;
  endtask

  task automatic alloc(input int n);
    drive_alloc(n);
    tick();
    idle_in();
  endtask

  task automatic complete(input int tag);
    drive_complete(tag, 1'b0);
    tick();
    idle_in();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #2;
    reset = 1'b1;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b0;
    idle_in();
    #12;
    reset = 1'b1;
    tick();

    // Reset state
    check("rst_count", 32'(rob_if.rob_count), 0);
    check("rst_empty", 32'(rob_if.rob_empty), 1);
    check("rst_full", 32'(rob_if.rob_full), 0);
    check("rst_commit", 32'(rob_if.commit_valid), 0);
    check("rst_flush", 32'(rob_if.flush), 0);

    // Async reset mid-run with 5 entries held and a committable head
    for (int i = 0; i < 5; i++) begin
      check("t1_tag", 32'(rob_if.alloc_tag), i);
      alloc(i);
    end
    check("t1_count5", 32'(rob_if.rob_count), 5);
    complete(0);
    check("t1_cv_before", 32'(rob_if.commit_valid), 1);
    #2;
    reset = 1'b0;
    #1;
    check("t1_async_count", 32'(rob_if.rob_count), 0);
    check("t1_async_empty", 32'(rob_if.rob_empty), 1);
    check("t1_async_cv", 32'(rob_if.commit_valid), 0);
    check("t1_async_tag", 32'(rob_if.alloc_tag), 0);
    #2;
    reset = 1'b1;
    tick();

    // Fill: 16 allocs, 17th dropped
    for (int i = 0; i < 16; i++) begin
      check("t2_tag", 32'(rob_if.alloc_tag), i);
      alloc(100 + i);
    end
    check("t2_full", 32'(rob_if.rob_full), 1);
    check("t2_count16", 32'(rob_if.rob_count), 16);
    check("t2_tag_wrap", 32'(rob_if.alloc_tag), 0);
    alloc(200);
    check("t2_drop_count", 32'(rob_if.rob_count), 16);
    check("t2_drop_tag", 32'(rob_if.alloc_tag), 0);
    complete(0);
    check("t2_cv", 32'(rob_if.commit_valid), 1);
    check("t2_preg", 32'(rob_if.commit_preg), 32'h24);
    check("t2_old_preg", 32'(rob_if.commit_old_preg), 32'h1b);
    check("t2_arch_rd", 32'(rob_if.commit_arch_rd), 32'h04);
    check("t2_has_rd", 32'(rob_if.commit_has_rd), 1);
    tick();
    check("t2_count15", 32'(rob_if.rob_count), 15);
    do_reset();

    // Out-of-order completion 3,1,2,0
    for (int i = 0; i < 4; i++) alloc(i);
    complete(3);
    check("t3_cv_a", 32'(rob_if.commit_valid), 0);
    complete(1);
    check("t3_cv_b", 32'(rob_if.commit_valid), 0);
    complete(2);
    check("t3_cv_c", 32'(rob_if.commit_valid), 0);
    drive_complete(0, 1'b0);
    check("t3_cv_same_cycle", 32'(rob_if.commit_valid), 0);
    tick();
    idle_in();
    for (int i = 0; i < 4; i++) begin
      check("t3_cv_seq", 32'(rob_if.commit_valid), 1);
      check("t3_preg_seq", 32'(rob_if.commit_preg), i);
      tick();
    end
    check("t3_cv_done", 32'(rob_if.commit_valid), 0);
    check("t3_empty", 32'(rob_if.rob_empty), 1);

    // Wrap: head/tail start at 4 and pass 15->0
    for (int k = 0; k < 20; k++) begin
      check("t4_tag", 32'(rob_if.alloc_tag), (4 + k) % 16);
      alloc(16 + k);
      complete((4 + k) % 16);
      check("t4_cv", 32'(rob_if.commit_valid), 1);
      check("t4_preg", 32'(rob_if.commit_preg), 16 + k);
      tick();
    end
    check("t4_count", 32'(rob_if.rob_count), 0);
    check("t4_tag_end", 32'(rob_if.alloc_tag), 8);

    // Simultaneous alloc+commit at count 8, then at full
    for (int i = 0; i < 8; i++) alloc(40 + i);
    complete(8);
    check("t5_count8", 32'(rob_if.rob_count), 8);
    check("t5_cv8", 32'(rob_if.commit_valid), 1);
    alloc(48);
    check("t5_count_same", 32'(rob_if.rob_count), 8);
    check("t5_tag", 32'(rob_if.alloc_tag), 1);
    for (int i = 0; i < 8; i++) alloc(49 + i);
    check("t5_full", 32'(rob_if.rob_full), 1);
    check("t5_count16", 32'(rob_if.rob_count), 16);
    complete(9);
    check("t5_cv_full", 32'(rob_if.commit_valid), 1);
    alloc(57);
    check("t5_count15", 32'(rob_if.rob_count), 15);
    check("t5_not_full", 32'(rob_if.rob_full), 0);
    check("t5_tag_kept", 32'(rob_if.alloc_tag), 9);
    do_reset();

    // Exception at tag 2 with tags 2-5 live
    for (int i = 0; i < 6; i++) alloc(60 + i);
    complete(0);
    check("t6_cv0", 32'(rob_if.commit_valid), 1);
    complete(1);
    check("t6_cv1", 32'(rob_if.commit_valid), 1);
    check("t6_preg1", 32'(rob_if.commit_preg), 61);
    tick();
    check("t6_count4", 32'(rob_if.rob_count), 4);
    drive_complete(2, 1'b1);
    drive_alloc(66);
    tick();
    idle_in();
    check("t6_flush", 32'(rob_if.flush), 1);
    check("t6_flush_pc", rob_if.flush_pc, 32'h10f8);
    check("t6_flush_cv", 32'(rob_if.commit_valid), 0);
    check("t6_flush_count", 32'(rob_if.rob_count), 5);
    drive_alloc(67);
    drive_complete(3, 1'b0);
    tick();
    idle_in();
    check("t6_flush_low", 32'(rob_if.flush), 0);
    check("t6_count0", 32'(rob_if.rob_count), 0);
    check("t6_empty", 32'(rob_if.rob_empty), 1);
    check("t6_tail0", 32'(rob_if.alloc_tag), 0);
    check("t6_cv_after", 32'(rob_if.commit_valid), 0);
    complete(3);
    check("t6_stale_cv", 32'(rob_if.commit_valid), 0);
    check("t6_stale_count", 32'(rob_if.rob_count), 0);
    alloc(70);
    complete(0);
    check("t6_new_cv", 32'(rob_if.commit_valid), 1);
    check("t6_new_preg", 32'(rob_if.commit_preg), 6);
    check("t6_new_old_preg", 32'(rob_if.commit_old_preg), 32'h39);
    tick();
    check("t6_new_empty", 32'(rob_if.rob_empty), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
